// File: rtl/downstream_pkg.sv
// Shared types and default sizing for the downstream write arbiter.
package downstream_pkg;

    localparam int unsigned DEF_N_REQ   = 4;
    localparam int unsigned DEF_ADDR_W  = 16;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_ACK     = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_t;

    // Bits needed for a wait counter that must hold values 0..timeout.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return unsigned'($clog2(timeout + 1));
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid_c,
    output logic [IDX_W-1:0] idx_c
);

    int unsigned cand;

    // Walk offsets from farthest to nearest so the nearest asserted request wins.
    always_comb begin
        valid_c = |req;
        idx_c   = '0;
        cand    = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = 32'(ptr) + (N_REQ - 1 - k);
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (req[IDX_W'(cand)]) begin
                idx_c = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/downstream_write_arbiter.sv
// Round-robin sharing of the downstream memwr/ack write path among N_REQ cache requesters.
module downstream_write_arbiter
    import downstream_pkg::*;
#(
    parameter int unsigned N_REQ   = DEF_N_REQ,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        done,
    output logic [N_REQ-1:0]        err,
    output logic                    memwr,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_data,
    input  logic                    ack,
    output logic                    busy
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = cnt_width(TIMEOUT);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               memwr_d, busy_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [DATA_W-1:0]  data_d;
    logic [N_REQ-1:0]   done_d, err_d;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               finish;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req     (req),
        .ptr     (rr_ptr_q),
        .valid_c (pick_valid),
        .idx_c   (pick_idx)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        memwr_d  = memwr;
        addr_d   = mem_addr;
        data_d   = mem_data;
        done_d   = '0;
        err_d    = '0;
        finish   = 1'b0;

        case (state_q)
            IDLE: begin
                memwr_d = 1'b0;
                // A stale ack from the previous write blocks the next issue.
                if (pick_valid && !ack) begin
                    idx_d   = pick_idx;
                    addr_d  = req_addr[32'(pick_idx) * ADDR_W +: ADDR_W];
                    data_d  = req_data[32'(pick_idx) * DATA_W +: DATA_W];
                    memwr_d = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                memwr_d = 1'b1;
                if (ack) begin
                    done_d[idx_q] = 1'b1;
                    finish        = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d[idx_q] = 1'b1;
                    finish       = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (finish) begin
                    memwr_d  = 1'b0;
                    rr_ptr_d = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                    state_d  = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                memwr_d = 1'b0;
                if (!ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                memwr_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset abandons any write without a done/err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            memwr    <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            done     <= '0;
            err      <= '0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            memwr    <= memwr_d;
            mem_addr <= addr_d;
            mem_data <= data_d;
            done     <= done_d;
            err      <= err_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_downstream_write_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model.
module tb_downstream_write_arbiter;

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 8;

    logic                    clk;
    logic                    rst_n;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        done;
    logic [N_REQ-1:0]        err;
    logic                    memwr;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_data;
    logic                    ack;
    logic                    busy;

    downstream_write_arbiter #(
        .N_REQ   (N_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .done     (done),
        .err      (err),
        .memwr    (memwr),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .ack      (ack),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_run;
    int unsigned n_fail;
    int unsigned cyc;

    // Transaction-level view: a write is outstanding, or the path is draining a held ack.
    bit                m_active;
    bit                m_drain;
    int unsigned       m_owner;
    int unsigned       m_ptr;
    int unsigned       m_start;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic [N_REQ-1:0]  m_done;
    logic [N_REQ-1:0]  m_err;
    int unsigned       ack_lat;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int unsigned first_from(input logic [N_REQ-1:0] r, input int unsigned p);
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
        end
        return N_REQ;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_drain  = 1'b0;
        m_ptr    = 0;
        m_done   = '0;
        m_err    = '0;
    endtask

    // One clock: apply the rules to the inputs present at the edge, then compare.
    task automatic step();
        logic [N_REQ-1:0]        r_s;
        logic                    a_s;
        logic [N_REQ*ADDR_W-1:0] ad_s;
        logic [N_REQ*DATA_W-1:0] d_s;
        int unsigned             elapsed;
        r_s  = req;
        a_s  = ack;
        ad_s = req_addr;
        d_s  = req_data;
        @(posedge clk);
        #1;
        cyc++;
        m_done = '0;
        m_err  = '0;
        if (m_active) begin
            elapsed = cyc - m_start;
            if (a_s || elapsed == TIMEOUT) begin
                if (a_s) m_done[m_owner] = 1'b1;
                else     m_err[m_owner]  = 1'b1;
                m_active = 1'b0;
                m_drain  = 1'b1;
                m_ptr    = (m_owner + 1) % N_REQ;
            end
        end else if (m_drain) begin
            if (!a_s) m_drain = 1'b0;
        end else if (r_s != '0 && !a_s) begin
            m_owner  = first_from(r_s, m_ptr);
            m_addr   = ad_s[m_owner*ADDR_W +: ADDR_W];
            m_data   = d_s[m_owner*DATA_W +: DATA_W];
            m_active = 1'b1;
            m_start  = cyc;
        end
        check_val("done", 64'(done), 64'(m_done));
        check_val("err", 64'(err), 64'(m_err));
        check_val("memwr", 64'(memwr), 64'(m_active));
        check_val("busy", 64'(busy), 64'(m_active || m_drain));
        if (m_active) begin
            check_val("mem_addr", 64'(mem_addr), 64'(m_addr));
            check_val("mem_data", 64'(mem_data), 64'(m_data));
        end
    endtask

    task automatic set_req(input int unsigned i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req[i] = 1'b1;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic drive_random();
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (m_done[i] || m_err[i]) begin
                req[i] = 1'b0;
            end else if (!req[i]) begin
                if ($urandom_range(2) == 0) set_req(i, ADDR_W'($urandom()), $urandom());
            end else if ($urandom_range(31) == 0) begin
                req[i] = 1'b0;
            end
            if (req[i] && $urandom_range(3) == 0) set_req(i, ADDR_W'($urandom()), $urandom());
        end
        if (m_active) begin
            if (m_start == cyc) ack_lat = $urandom_range(1, TIMEOUT + 1);
            ack = (cyc - m_start >= ack_lat);
        end else if (m_drain) begin
            if (m_err != '0) ack = ($urandom_range(1) == 1);
            else             ack = ack && ($urandom_range(1) == 1);
        end else begin
            ack = ($urandom_range(7) == 0);
        end
    endtask

    initial begin
        int unsigned last;
        int unsigned hi;
        bit          seen;
        n_run    = 0;
        n_fail   = 0;
        cyc      = 0;
        ack_lat  = 1;
        rst_n    = 1'b0;
        req      = '0;
        ack      = 1'b0;
        req_addr = '0;
        req_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_memwr", 64'(memwr), 64'(0));
        check_val("rst_busy", 64'(busy), 64'(0));
        check_val("rst_done", 64'(done), 64'(0));
        check_val("rst_err", 64'(err), 64'(0));
        check_val("rst_addr", 64'(mem_addr), 64'(0));
        check_val("rst_data", 64'(mem_data), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin with all requesters held and a one-cycle registered ack responder.
        for (int unsigned i = 0; i < N_REQ; i++) set_req(i, ADDR_W'($urandom()), $urandom());
        last = 0;
        for (int unsigned w = 0; w < 5; w++) begin
            seen = 1'b0;
            for (int k = 0; k < 12 && !seen; k++) begin
                step();
                ack  = m_active && (cyc - m_start >= 1);
                seen = (m_done != '0);
            end
            if (!seen) begin
                check_val("rr_no_done", 64'(0), 64'(1));
            end else begin
                check_val("rr_order", 64'(done), 64'(1) << (w % N_REQ));
                if (w > 0) check_val("rr_period", 64'(cyc - last), 64'(4));
                last = cyc;
            end
        end
        req = '0;
        ack = 1'b0;
        step();
        step();

        // Single write with ack three cycles after memwr.
        set_req(1, 16'h1234, 32'hDEADBEEF);
        step();
        for (int k = 0; k < 3; k++) step();
        check_val("single_addr", 64'(mem_addr), 64'(16'h1234));
        check_val("single_data", 64'(mem_data), 64'(32'hDEADBEEF));
        ack = 1'b1;
        step();
        check_val("single_done", 64'(done), 64'(4'b0010));
        check_val("single_memwr_low", 64'(memwr), 64'(0));
        req = '0;
        ack = 1'b0;
        step();
        check_val("single_done_once", 64'(done), 64'(0));
        step();

        // Timeout: ack never rises.
        set_req(3, ADDR_W'($urandom()), $urandom());
        step();
        hi = memwr ? 1 : 0;
        for (int k = 0; k < 20 && memwr; k++) begin
            step();
            if (memwr) hi++;
        end
        check_val("to_memwr_cycles", 64'(hi), 64'(TIMEOUT));
        check_val("to_err", 64'(err), 64'(4'b1000));
        check_val("to_no_done", 64'(done), 64'(0));
        req = '0;
        ack = 1'b1;
        step();
        check_val("to_late_ack_busy", 64'(busy), 64'(1));
        ack = 1'b0;
        step();
        check_val("to_release_idle", 64'(busy), 64'(0));

        // Stale ack blocks issue until it drops.
        ack = 1'b1;
        set_req(0, ADDR_W'($urandom()), $urandom());
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("stale_hold", 64'(memwr), 64'(0));
        end
        ack = 1'b0;
        step();
        check_val("stale_issue", 64'(memwr), 64'(1));
        step();
        ack = 1'b1;
        step();
        check_val("stale_done", 64'(done), 64'(4'b0001));
        req = '0;
        ack = 1'b0;
        step();
        step();

        // Ack arriving on the final count wins over the timeout.
        set_req(1, ADDR_W'($urandom()), $urandom());
        step();
        for (int k = 0; k < int'(TIMEOUT) - 1; k++) step();
        ack = 1'b1;
        step();
        check_val("race_done", 64'(done), 64'(4'b0010));
        check_val("race_err", 64'(err), 64'(0));
        req = '0;
        ack = 1'b0;
        step();
        step();

        // Reset in the middle of a write, then a fresh issue from pointer 0.
        set_req(0, ADDR_W'($urandom()), $urandom());
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_memwr", 64'(memwr), 64'(0));
        check_val("mid_rst_busy", 64'(busy), 64'(0));
        check_val("mid_rst_done", 64'(done), 64'(0));
        check_val("mid_rst_err", 64'(err), 64'(0));
        model_reset();
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req[0] = 1'b0;
        set_req(2, 16'h0040, $urandom());
        step();
        check_val("post_rst_addr", 64'(mem_addr), 64'(16'h0040));
        step();
        ack = 1'b1;
        step();
        check_val("post_rst_done", 64'(done), 64'(4'b0100));
        req = '0;
        ack = 1'b0;
        step();
        step();

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            drive_random();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
